// File: rtl/gbuf_port_arbiter.sv
// Arbitrates one single-port global-buffer BRAM between the TPU (absolute priority) and a host req/ack port.
// Optional macro GBUF_WAIT_STAT_EN adds host_wait_cnt_o (per-request blocked-cycle counter).
module gbuf_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 128,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tpu_busy_i,
  input  logic                  tpu_en_i,
  input  logic                  tpu_we_i,
  input  logic [ADDR_WIDTH-1:0] tpu_addr_i,
  input  logic [WORD_WIDTH-1:0] tpu_wdata_i,
  output logic [WORD_WIDTH-1:0] tpu_rdata_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [WORD_WIDTH-1:0] host_wdata_i,
  output logic                  host_ack_o,
  output logic [WORD_WIDTH-1:0] host_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i
`ifdef GBUF_WAIT_STAT_EN
  ,
  output logic [15:0]           host_wait_cnt_o
`endif
);

  if (MEM_LAT != 1) begin : g_lat_check
    $error("gbuf_port_arbiter: only MEM_LAT == 1 is supported");
  end

  // The issue cycle is combinational out of IDLE/WAIT, so it needs no state of its own;
  // RESP is the registered ack cycle in which host_req_i is ignored.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_blocked;
  logic                  w_issue;
  logic                  r_ack;
  logic                  r_rd_tag;
  logic [WORD_WIDTH-1:0] r_rdata;

  always_comb begin
    w_blocked = tpu_en_i | tpu_busy_i;
    w_issue   = rst_ni & host_req_i & ~w_blocked & (r_state != S_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_rd_tag <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_issue;
      r_rd_tag <= w_issue & ~host_we_i;
      if (r_rd_tag) r_rdata <= mem_rdata_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (host_req_i) w_state_nxt = w_blocked ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (!host_req_i)     w_state_nxt = S_IDLE;
        else if (!w_blocked) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = host_addr_i;
    mem_wdata_o = host_wdata_i;
    if (tpu_en_i) begin
      mem_en_o    = 1'b1;
      mem_we_o    = tpu_we_i;
      mem_addr_o  = tpu_addr_i;
      mem_wdata_o = tpu_wdata_i;
    end else if (w_issue) begin
      mem_en_o    = 1'b1;
      mem_we_o    = host_we_i;
    end
  end

  assign tpu_rdata_o  = mem_rdata_i;
  // BRAM data arrives in the ack cycle itself; the register only holds it afterwards.
  assign host_rdata_o = r_rd_tag ? mem_rdata_i : r_rdata;
  assign host_ack_o   = r_ack;

`ifdef GBUF_WAIT_STAT_EN
  logic [15:0] r_wait_cnt;

  // Restarts when a request is first seen, so the value survives until its ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_IDLE && host_req_i) begin
      r_wait_cnt <= w_blocked ? 16'd1 : 16'd0;
    end else if (r_state == S_WAIT && host_req_i && w_blocked && r_wait_cnt != '1) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign host_wait_cnt_o = r_wait_cnt;
`endif

endmodule

// File: tb/tb_gbuf_port_arbiter.sv
// Self-checking bench for gbuf_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference of the arbitration rules and a golden memory.
module tb_gbuf_port_arbiter;
  localparam int AW = 12;
  localparam int WW = 128;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          tpu_busy_i, tpu_en_i, tpu_we_i;
  logic [AW-1:0] tpu_addr_i;
  logic [WW-1:0] tpu_wdata_i, tpu_rdata_o;
  logic          host_req_i, host_we_i, host_ack_o;
  logic [AW-1:0] host_addr_i;
  logic [WW-1:0] host_wdata_i, host_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [WW-1:0] mem_wdata_o, mem_rdata_i;
`ifdef GBUF_WAIT_STAT_EN
  logic [15:0]   host_wait_cnt_o;
`endif

  logic [WW-1:0] bram [0:4095];
  logic [WW-1:0] gm   [0:4095];
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  gbuf_port_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MEM_LAT(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tpu_busy_i(tpu_busy_i), .tpu_en_i(tpu_en_i),
    .tpu_we_i(tpu_we_i), .tpu_addr_i(tpu_addr_i), .tpu_wdata_i(tpu_wdata_i),
    .tpu_rdata_o(tpu_rdata_o), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o),
    .host_rdata_o(host_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef GBUF_WAIT_STAT_EN
    , .host_wait_cnt_o(host_wait_cnt_o)
`endif
  );

  // Single-port BRAM, one-cycle read latency, read output unchanged on writes.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) bram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i      <= bram[mem_addr_o];
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs;
    tpu_busy_i = 0; tpu_en_i = 0; tpu_we_i = 0; tpu_addr_i = '0; tpu_wdata_i = '0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
  endtask

  task automatic test_reset;
    rst_ni = 0;
    idle_inputs();
    host_req_i = 1;
    repeat (2) @(negedge clk_i);
    #1;
    total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b exp=0", host_ack_o); end
    total++; if (host_rdata_o !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", host_rdata_o); end
    total++; if (mem_en_o !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en_o); end
    @(negedge clk_i);
    host_req_i = 0;
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_host_write;
    host_req_i = 1; host_we_i = 1; host_addr_i = 12'h010; host_wdata_i = 128'h1234;
    #1;
    total++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b1) begin bad++; $display("FAIL wr_en got en=%0b we=%0b exp 1/1", mem_en_o, mem_we_o); end
    total++; if (mem_addr_o !== 12'h010) begin bad++; $display("FAIL wr_addr got=%h exp=010", mem_addr_o); end
    total++; if (mem_wdata_o !== 128'h1234) begin bad++; $display("FAIL wr_data got=%h exp=1234", mem_wdata_o); end
    total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL wr_early_ack got=%0b exp=0", host_ack_o); end
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b1) begin bad++; $display("FAIL wr_ack got=%0b exp=1", host_ack_o); end
    host_req_i = 0;
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%0b exp=0", host_ack_o); end
    total++; if (bram[12'h010] !== 128'h1234) begin bad++; $display("FAIL wr_commit got=%h exp=1234", bram[12'h010]); end
  endtask

  task automatic test_host_read;
    int acc = 0;
    host_req_i = 1; host_we_i = 0; host_addr_i = 12'h010;
    #1; if (mem_en_o) acc++;
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b1) begin bad++; $display("FAIL rd_ack got=%0b exp=1", host_ack_o); end
    total++; if (host_rdata_o !== 128'h1234) begin bad++; $display("FAIL rd_data got=%h exp=1234", host_rdata_o); end
    #1; if (mem_en_o) acc++;
    @(negedge clk_i);
    host_req_i = 0;
    total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got=%0b exp=0", host_ack_o); end
    #1; if (mem_en_o) acc++;
    total++; if (acc != 1) begin bad++; $display("FAIL rd_single_access got=%0d exp=1", acc); end
    @(negedge clk_i);
  endtask

  task automatic test_tpu_priority;
    logic [WW-1:0] tv [10];
    logic [WW-1:0] hv;
    hv = {4{$urandom}};
    bram[12'h200] = hv;
    for (int i = 0; i < 10; i++) begin
      tv[i] = {4{$urandom}};
      bram[12'h100 + i] = tv[i];
    end
    host_req_i = 1; host_we_i = 0; host_addr_i = 12'h200;
    for (int i = 0; i < 10; i++) begin
      tpu_en_i = 1; tpu_we_i = 0; tpu_addr_i = 12'(12'h100 + i);
      #1;
      total++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'(12'h100 + i)) begin
        bad++; $display("FAIL prio_addr[%0d] got en=%0b we=%0b a=%h exp 1/0/%h", i, mem_en_o, mem_we_o, mem_addr_o, 12'h100 + i);
      end
      if (i > 0) begin
        total++; if (tpu_rdata_o !== tv[i-1]) begin bad++; $display("FAIL prio_tpu_rd[%0d] got=%h exp=%h", i-1, tpu_rdata_o, tv[i-1]); end
      end
      total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL prio_no_ack[%0d] got=%0b exp=0", i, host_ack_o); end
      @(negedge clk_i);
    end
    tpu_en_i = 0;
    total++; if (tpu_rdata_o !== tv[9]) begin bad++; $display("FAIL prio_tpu_rd[9] got=%h exp=%h", tpu_rdata_o, tv[9]); end
    #1;
    total++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'h200) begin
      bad++; $display("FAIL prio_host_issue got en=%0b we=%0b a=%h exp 1/0/200", mem_en_o, mem_we_o, mem_addr_o);
    end
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b1 || host_rdata_o !== hv) begin
      bad++; $display("FAIL prio_host_ack got ack=%0b d=%h exp 1/%h", host_ack_o, host_rdata_o, hv);
    end
    host_req_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_busy_block;
    int early = 0;
    tpu_busy_i = 1;
    host_req_i = 1; host_we_i = 1; host_addr_i = 12'h020; host_wdata_i = 128'h5555;
    for (int i = 0; i < 20; i++) begin
      #1; if (mem_en_o || host_ack_o) early++;
      @(negedge clk_i);
    end
    total++; if (early != 0) begin bad++; $display("FAIL busy_blocked got=%0d exp=0 access/ack cycles", early); end
    tpu_busy_i = 0;
    #1;
    total++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 12'h020) begin
      bad++; $display("FAIL busy_issue got en=%0b we=%0b a=%h exp 1/1/020", mem_en_o, mem_we_o, mem_addr_o);
    end
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b1) begin bad++; $display("FAIL busy_ack got=%0b exp=1", host_ack_o); end
`ifdef GBUF_WAIT_STAT_EN
    total++; if (host_wait_cnt_o !== 16'd20) begin bad++; $display("FAIL busy_wait_cnt got=%0d exp=20", host_wait_cnt_o); end
`endif
    host_req_i = 0;
    @(negedge clk_i);
    total++; if (bram[12'h020] !== 128'h5555) begin bad++; $display("FAIL busy_commit got=%h exp=5555", bram[12'h020]); end
  endtask

  task automatic test_reset_mid;
    logic [WW-1:0] v;
    v = {4{$urandom}};
    bram[12'h030] = v;
    host_req_i = 1; host_we_i = 0; host_addr_i = 12'h030;
    #1;
    total++; if (mem_en_o !== 1'b1) begin bad++; $display("FAIL rstmid_issue got=%0b exp=1", mem_en_o); end
    rst_ni = 0;
    #1;
    total++; if (host_ack_o !== 1'b0 || mem_en_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_in_reset got ack=%0b en=%0b exp 0/0", host_ack_o, mem_en_o);
    end
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL rstmid_lost_ack got=%0b exp=0", host_ack_o); end
    rst_ni = 1;
    #1;
    total++; if (mem_en_o !== 1'b1 || mem_addr_o !== 12'h030) begin
      bad++; $display("FAIL rstmid_reissue got en=%0b a=%h exp 1/030", mem_en_o, mem_addr_o);
    end
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b1 || host_rdata_o !== v) begin
      bad++; $display("FAIL rstmid_ack got ack=%0b d=%h exp 1/%h", host_ack_o, host_rdata_o, v);
    end
    host_req_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_collision;
    tpu_en_i = 1; tpu_we_i = 1; tpu_addr_i = 12'h300; tpu_wdata_i = 128'hABCD;
    host_req_i = 1; host_we_i = 0; host_addr_i = 12'h300;
    #1;
    total++; if (mem_we_o !== 1'b1 || mem_addr_o !== 12'h300 || mem_wdata_o !== 128'hABCD) begin
      bad++; $display("FAIL coll_tpu_wins got we=%0b a=%h d=%h exp 1/300/abcd", mem_we_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    tpu_en_i = 0; tpu_we_i = 0;
    total++; if (host_ack_o !== 1'b0) begin bad++; $display("FAIL coll_no_ack got=%0b exp=0", host_ack_o); end
    #1;
    total++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'h300) begin
      bad++; $display("FAIL coll_host_issue got en=%0b we=%0b a=%h exp 1/0/300", mem_en_o, mem_we_o, mem_addr_o);
    end
    @(negedge clk_i);
    total++; if (host_ack_o !== 1'b1 || host_rdata_o !== 128'hABCD) begin
      bad++; $display("FAIL coll_ack got ack=%0b d=%h exp 1/abcd", host_ack_o, host_rdata_o);
    end
    host_req_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_wait_drop;
    int acts = 0;
    tpu_en_i = 1; tpu_we_i = 0; tpu_addr_i = 12'h040;
    host_req_i = 1; host_we_i = 1; host_addr_i = 12'h050; host_wdata_i = 128'h77;
    repeat (2) @(negedge clk_i);
    host_req_i = 0; tpu_en_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (mem_en_o || host_ack_o) acts++;
      @(negedge clk_i);
    end
    total++; if (acts != 0) begin bad++; $display("FAIL drop_no_access got=%0d exp=0", acts); end
  endtask

  task automatic test_random;
    logic          pend, in_ack, exp_ack, issue, t_rd_prev, h_we, exp_en;
    logic [AW-1:0] h_addr;
    logic [WW-1:0] h_wd, exp_h, exp_t;
    pend = 0; exp_ack = 0; t_rd_prev = 0; h_we = 0; h_addr = '0; h_wd = '0; exp_h = '0; exp_t = '0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_i);
      total++; if (host_ack_o !== exp_ack) begin bad++; $display("FAIL rnd_ack[%0d] got=%0b exp=%0b", c, host_ack_o, exp_ack); end
      if (exp_ack && !h_we) begin
        total++; if (host_rdata_o !== exp_h) begin bad++; $display("FAIL rnd_hrd[%0d] got=%h exp=%h", c, host_rdata_o, exp_h); end
      end
      if (t_rd_prev) begin
        total++; if (tpu_rdata_o !== exp_t) begin bad++; $display("FAIL rnd_trd[%0d] got=%h exp=%h", c, tpu_rdata_o, exp_t); end
      end
      in_ack = exp_ack;
      if (exp_ack) pend = 0;
      if (!in_ack) begin
        if (!pend && $urandom_range(0, 1) == 1) begin
          pend   = 1;
          h_we   = 1'($urandom_range(0, 1));
          h_addr = 12'(12'h800 + $urandom_range(0, 15));
          h_wd   = {4{$urandom}};
        end
        host_req_i = pend; host_we_i = h_we; host_addr_i = h_addr; host_wdata_i = h_wd;
      end
      tpu_en_i    = ($urandom_range(0, 99) < 40);
      tpu_we_i    = 1'($urandom_range(0, 1));
      tpu_addr_i  = 12'(12'h800 + $urandom_range(0, 15));
      tpu_wdata_i = {4{$urandom}};
      tpu_busy_i  = ($urandom_range(0, 99) < 15);
      #1;
      issue  = pend && !in_ack && !tpu_en_i && !tpu_busy_i;
      exp_en = tpu_en_i || issue;
      total++; if (mem_en_o !== exp_en) begin bad++; $display("FAIL rnd_en[%0d] got=%0b exp=%0b", c, mem_en_o, exp_en); end
      if (tpu_en_i) begin
        total++; if (mem_we_o !== tpu_we_i || mem_addr_o !== tpu_addr_i || (tpu_we_i && mem_wdata_o !== tpu_wdata_i)) begin
          bad++; $display("FAIL rnd_tpu_mux[%0d] got we=%0b a=%h exp we=%0b a=%h", c, mem_we_o, mem_addr_o, tpu_we_i, tpu_addr_i);
        end
        if (tpu_we_i) gm[tpu_addr_i] = tpu_wdata_i;
        else exp_t = gm[tpu_addr_i];
      end else if (issue) begin
        total++; if (mem_we_o !== h_we || mem_addr_o !== h_addr || (h_we && mem_wdata_o !== h_wd)) begin
          bad++; $display("FAIL rnd_host_mux[%0d] got we=%0b a=%h exp we=%0b a=%h", c, mem_we_o, mem_addr_o, h_we, h_addr);
        end
        if (h_we) gm[h_addr] = h_wd;
        else exp_h = gm[h_addr];
      end else begin
        total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL rnd_idle_we[%0d] got=%0b exp=0", c, mem_we_o); end
      end
      t_rd_prev = tpu_en_i && !tpu_we_i;
      exp_ack   = issue;
    end
    @(negedge clk_i);
    total++; if (host_ack_o !== exp_ack) begin bad++; $display("FAIL rnd_ack_end got=%0b exp=%0b", host_ack_o, exp_ack); end
    idle_inputs();
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      bram[i] = '0;
      gm[i]   = '0;
    end
    mem_rdata_i = '0;
    test_reset();
    test_host_write();
    test_host_read();
    test_tpu_priority();
    test_busy_block();
    test_reset_mid();
    test_collision();
    test_wait_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
